cpu_prog_ctrl: RTL and testbench
================================

Name: cpu_prog_ctrl

Overview:
Program-load and execution controller placed between a byte-stream host link (UART RX) and cpu_core. It decodes single-byte host commands. It writes received instruction words into instruction memory through the core's imem write port. It sequences core execution by driving the core enable in run-until-halt or single-step mode. Loading and execution are mutually exclusive.

Parameters:
NB_INSTRUCTION, 32, width of an instruction word; must be a multiple of NB_BYTE.
IMEM_ADDR_WIDTH, 5, instruction memory word-address width.
NB_BYTE, 8, host byte width.

Ports:
clk  in  1  system clock, rising edge.
i_rst  in  1  reset, synchronous, active-high.
i_rx_data  in  NB_BYTE  host byte.
i_rx_valid  in  1  one-cycle strobe qualifying i_rx_data.
i_halt  in  1  core reached halt instruction; level.
o_imem_data  out  NB_INSTRUCTION  assembled instruction word.
o_imem_waddr  out  IMEM_ADDR_WIDTH  instruction memory word address.
o_imem_wen  out  1  instruction memory write strobe.
o_mem_wsize  out  2  write size: 2'b10 (word) when o_imem_wen=1, else 2'b00.
o_cpu_en  out  1  core clock enable.
o_ack  out  1  one-cycle completion pulse to host.
o_state  out  3  current FSM state, for debug.

Behaviour:
- Interface: one clock, clk. Reset i_rst is synchronous and active-high.
- Reset: state=IDLE, all outputs 0, word/byte/address/count registers 0. Reset mid-load discards any partial word. Reset mid-run drops o_cpu_en on the next edge.
- All outputs are registered. No output depends combinationally on an input.
- State encodings: IDLE=0, LD_CNT=1, LD_BYTE=2, RUN=3, STEP=4.
- IDLE, on i_rx_valid:
  - 0x4C 'L' -> LD_CNT.
  - 0x52 'R' -> RUN.
  - 0x53 'S' -> STEP.
  - Any other byte is ignored; i_halt is ignored.
- LD_CNT, on i_rx_valid: latch count N = i_rx_data.
  - N=0: go to IDLE and pulse o_ack.
  - N>0: clear word address to 0 and byte index to 0, then go to LD_BYTE.
- LD_BYTE:
  - Each i_rx_valid byte is placed little-endian (first byte in bits [7:0]); the byte index increments.
  - On the edge accepting byte NB_INSTRUCTION/NB_BYTE, o_imem_wen=1 for exactly the next cycle, with o_imem_data=word and o_imem_waddr=current address.
  - On that same edge, the address increments (wraps modulo 2^IMEM_ADDR_WIDTH, overwriting from 0) and the remaining count decrements.
  - Last word: go to IDLE; o_ack pulses in the same cycle as the final o_imem_wen.
  - The FSM can accept a byte in every cycle, including the write cycle; no byte is dropped.
- RUN: o_cpu_en=1 in every cycle spent in RUN, starting the cycle after the 'R' byte is accepted.
  - i_halt=1 or i_rx_valid with byte 0x48 'H' -> IDLE; o_cpu_en=0 and o_ack=1 in the following cycle.
  - Both events in the same cycle produce a single o_ack.
  - Other bytes are ignored.
- STEP: o_cpu_en=1 for exactly one cycle, then IDLE; o_ack pulses in the first IDLE cycle. Bytes arriving in STEP are ignored.
- Invariants: o_imem_wen and o_cpu_en are never high in the same cycle; o_ack is never high for two consecutive cycles.

Test Plan:
- Reset check: assert i_rst for 2 cycles during LD_BYTE -> all outputs 0, o_state=0; next 'L' restarts at address 0.
- Load two words: 4C,02,78,56,34,12,EF,BE,AD,DE, back-to-back one byte per cycle -> two writes:
  - wen pulse 1: addr 0, data 0x12345678, o_mem_wsize=2'b10.
  - wen pulse 2: addr 1, data 0xDEADBEEF.
  - o_ack coincides with the second wen; no byte lost.
- Address wrap: load N=33 words with value=index -> the 33rd write targets addr 0 with data 32; o_ack after write 33.
- Empty load: 4C,00 -> no wen; o_ack the cycle after the 00 byte; state IDLE.
- Run-to-halt: 'R', then raise i_halt 10 cycles later -> o_cpu_en high exactly 10 cycles, then low with one o_ack.
  - Repeat with 'H' and i_halt in the same cycle -> single o_ack.
- Single step: 'S' -> o_cpu_en high exactly 1 cycle, then o_ack.
  - 0x41 in IDLE -> no output change.
  - 'L' sent during RUN -> ignored, no wen.

Source files
------------

// File: rtl/cpu_prog_ctrl.sv
// cpu_prog_ctrl: host-command driven program loader and execution sequencer.
// Host bytes select between loading instruction words into instruction memory
// (little-endian byte assembly) and running the core, either until halt or
// for a single step. Loading and execution never overlap.
module cpu_prog_ctrl #(
    parameter int NB_INSTRUCTION  = 32,
    parameter int IMEM_ADDR_WIDTH = 5,
    parameter int NB_BYTE         = 8
) (
    input  logic                       clk,
    input  logic                       i_rst,
    input  logic [NB_BYTE-1:0]         i_rx_data,
    input  logic                       i_rx_valid,
    input  logic                       i_halt,
    output logic [NB_INSTRUCTION-1:0]  o_imem_data,
    output logic [IMEM_ADDR_WIDTH-1:0] o_imem_waddr,
    output logic                       o_imem_wen,
    output logic [1:0]                 o_mem_wsize,
    output logic                       o_cpu_en,
    output logic                       o_ack,
    output logic [2:0]                 o_state
);

    localparam int NBYTES = NB_INSTRUCTION / NB_BYTE;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NBYTES - 1);
    localparam logic [NB_BYTE-1:0] CMD_LOAD  = NB_BYTE'(8'h4C);
    localparam logic [NB_BYTE-1:0] CMD_RUN   = NB_BYTE'(8'h52);
    localparam logic [NB_BYTE-1:0] CMD_STEP  = NB_BYTE'(8'h53);
    localparam logic [NB_BYTE-1:0] CMD_HALT  = NB_BYTE'(8'h48);
    localparam logic [NB_BYTE-1:0] ONE_WORD  = NB_BYTE'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LD_CNT  = 3'd1,
        LD_BYTE = 3'd2,
        RUN     = 3'd3,
        STEP    = 3'd4
    } state_t;

    state_t                       state;
    logic [NB_INSTRUCTION-1:0]    word;
    logic [IMEM_ADDR_WIDTH-1:0]   addr;
    logic [IMEM_ADDR_WIDTH-1:0]   waddr;
    logic [IDX_W-1:0]             byte_idx;
    logic [NB_BYTE-1:0]           count;
    logic                         wen;
    logic [1:0]                   wsize;
    logic                         cpu_en;
    logic                         ack;

    // Command decode, word assembly and run sequencing; all outputs registered.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state    <= IDLE;
            word     <= '0;
            addr     <= '0;
            waddr    <= '0;
            byte_idx <= '0;
            count    <= '0;
            wen      <= 1'b0;
            wsize    <= 2'b00;
            cpu_en   <= 1'b0;
            ack      <= 1'b0;
        end else begin
            wen    <= 1'b0;
            wsize  <= 2'b00;
            cpu_en <= 1'b0;
            ack    <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_rx_valid) begin
                        if (i_rx_data == CMD_LOAD) begin
                            state <= LD_CNT;
                        end else if (i_rx_data == CMD_RUN) begin
                            state  <= RUN;
                            cpu_en <= 1'b1;
                        end else if (i_rx_data == CMD_STEP) begin
                            state  <= STEP;
                            cpu_en <= 1'b1;
                        end
                    end
                end
                LD_CNT: begin
                    if (i_rx_valid) begin
                        if (i_rx_data == '0) begin
                            state <= IDLE;
                            ack   <= 1'b1;
                        end else begin
                            count    <= i_rx_data;
                            addr     <= '0;
                            byte_idx <= '0;
                            state    <= LD_BYTE;
                        end
                    end
                end
                LD_BYTE: begin
                    if (i_rx_valid) begin
                        // Shift in from the top so the first byte ends in the low lane.
                        word <= {i_rx_data, word[NB_INSTRUCTION-1:NB_BYTE]};
                        if (byte_idx == LAST_IDX) begin
                            byte_idx <= '0;
                            wen      <= 1'b1;
                            wsize    <= 2'b10;
                            waddr    <= addr;
                            addr     <= addr + 1'b1;
                            count    <= count - 1'b1;
                            if (count == ONE_WORD) begin
                                state <= IDLE;
                                ack   <= 1'b1;
                            end
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (i_halt || (i_rx_valid && (i_rx_data == CMD_HALT))) begin
                        state <= IDLE;
                        ack   <= 1'b1;
                    end else begin
                        cpu_en <= 1'b1;
                    end
                end
                STEP: begin
                    state <= IDLE;
                    ack   <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign o_imem_data  = word;
    assign o_imem_waddr = waddr;
    assign o_imem_wen   = wen;
    assign o_mem_wsize  = wsize;
    assign o_cpu_en     = cpu_en;
    assign o_ack        = ack;
    assign o_state      = state;

endmodule

// File: tb/tb_cpu_prog_ctrl.sv
// Bench for cpu_prog_ctrl: directed host byte sequences, a behavioural model
// compared every cycle, and literal expectations on each scenario's outcome.
module tb_cpu_prog_ctrl;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [7:0]  i_rx_data = 8'h00;
    logic        i_rx_valid = 1'b0;
    logic        i_halt = 1'b0;
    logic [31:0] o_imem_data;
    logic [4:0]  o_imem_waddr;
    logic        o_imem_wen;
    logic [1:0]  o_mem_wsize;
    logic        o_cpu_en;
    logic        o_ack;
    logic [2:0]  o_state;

    always #5 clk = ~clk;

    cpu_prog_ctrl #(
        .NB_INSTRUCTION (32),
        .IMEM_ADDR_WIDTH(5),
        .NB_BYTE        (8)
    ) dut (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_rx_data   (i_rx_data),
        .i_rx_valid  (i_rx_valid),
        .i_halt      (i_halt),
        .o_imem_data (o_imem_data),
        .o_imem_waddr(o_imem_waddr),
        .o_imem_wen  (o_imem_wen),
        .o_mem_wsize (o_mem_wsize),
        .o_cpu_en    (o_cpu_en),
        .o_ack       (o_ack),
        .o_state     (o_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs as seen by the DUT at each rising edge.
    logic       s_rst = 1'b1;
    logic       s_valid = 1'b0;
    logic       s_halt = 1'b0;
    logic [7:0] s_data = 8'h00;
    always @(posedge clk) begin
        s_rst   <= i_rst;
        s_valid <= i_rx_valid;
        s_data  <= i_rx_data;
        s_halt  <= i_halt;
    end

    // Behavioural model: activity name, words left, collected bytes, word number.
    string       m_mode = "idle";
    int          m_left = 0;
    int          m_addr = 0;
    logic [7:0]  m_bytes[$];
    int          e_state = 0, e_cpu_en = 0, e_ack = 0, e_wen = 0, e_wsize = 0, e_waddr = 0;
    logic [31:0] e_data = 32'h0;
    bit          e_chk_data = 1'b0;

    task automatic model_step();
        e_cpu_en = 0; e_ack = 0; e_wen = 0; e_wsize = 0; e_chk_data = 1'b0;
        if (s_rst) begin
            m_mode = "idle"; m_left = 0; m_addr = 0; m_bytes.delete();
            e_data = 32'h0; e_waddr = 0; e_chk_data = 1'b1;
        end else if (m_mode == "idle") begin
            if (s_valid && s_data == 8'h4C) m_mode = "count";
            else if (s_valid && s_data == 8'h52) begin m_mode = "run"; e_cpu_en = 1; end
            else if (s_valid && s_data == 8'h53) begin m_mode = "step"; e_cpu_en = 1; end
        end else if (m_mode == "count") begin
            if (s_valid) begin
                if (s_data == 8'h00) begin m_mode = "idle"; e_ack = 1; end
                else begin m_left = int'(s_data); m_addr = 0; m_bytes.delete(); m_mode = "load"; end
            end
        end else if (m_mode == "load") begin
            if (s_valid) begin
                m_bytes.push_back(s_data);
                if (m_bytes.size() == 4) begin
                    e_wen = 1; e_wsize = 2; e_chk_data = 1'b1;
                    e_data  = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                    e_waddr = m_addr % 32;
                    m_addr  = m_addr + 1;
                    m_left  = m_left - 1;
                    m_bytes.delete();
                    if (m_left == 0) begin m_mode = "idle"; e_ack = 1; end
                end
            end
        end else if (m_mode == "run") begin
            if (s_halt || (s_valid && s_data == 8'h48)) begin m_mode = "idle"; e_ack = 1; end
            else e_cpu_en = 1;
        end else begin
            m_mode = "idle"; e_ack = 1;
        end
        case (m_mode)
            "idle":  e_state = 0;
            "count": e_state = 1;
            "load":  e_state = 2;
            "run":   e_state = 3;
            default: e_state = 4;
        endcase
    endtask

    typedef struct {
        int          addr;
        logic [31:0] data;
        logic [1:0]  wsize;
    } wr_t;
    wr_t wr_log[$];
    int  en_count = 0, ack_count = 0, wen_count = 0, ackwen_count = 0;
    logic prev_ack = 1'b0;

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            model_step();
            check("state",  32'(o_state),     e_state);
            check("cpu_en", 32'(o_cpu_en),    e_cpu_en);
            check("ack",    32'(o_ack),       e_ack);
            check("wen",    32'(o_imem_wen),  e_wen);
            check("wsize",  32'(o_mem_wsize), e_wsize);
            if (e_chk_data) begin
                check("imem_data",  o_imem_data,       e_data);
                check("imem_waddr", 32'(o_imem_waddr), e_waddr);
            end
            check("wen_en_exclusive", 32'(o_imem_wen & o_cpu_en), 32'd0);
            check("ack_not_back_to_back", 32'(o_ack & prev_ack), 32'd0);
            prev_ack = o_ack;
            en_count     += int'(o_cpu_en);
            ack_count    += int'(o_ack);
            wen_count    += int'(o_imem_wen);
            ackwen_count += int'(o_ack & o_imem_wen);
            if (o_imem_wen) wr_log.push_back('{int'(o_imem_waddr), o_imem_data, o_mem_wsize});
        end
    end

    task automatic drive(input logic v, input logic [7:0] d, input logic h);
        @(negedge clk);
        i_rx_valid = v; i_rx_data = d; i_halt = h;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send(input logic [7:0] b);
        drive(1'b1, b, 1'b0);
    endtask

    task automatic settle();
        idle(3);
        #1;
    endtask

    task automatic clear_counts();
        en_count = 0; ack_count = 0; wen_count = 0; ackwen_count = 0;
        wr_log.delete();
    endtask

    logic [7:0] two_words[10] = '{8'h4C, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

    initial begin
        // Power-on reset.
        @(negedge clk);
        @(negedge clk);
        i_rst = 1'b0;
        settle();
        check("por_state", 32'(o_state), 32'd0);
        check("por_data",  o_imem_data,  32'd0);

        // Reset for two cycles in the middle of a load.
        clear_counts();
        send(8'h4C); send(8'h03); send(8'h11); send(8'h22);
        @(negedge clk); i_rx_valid = 1'b0; i_rst = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        check("rst_state",  32'(o_state),      32'd0);
        check("rst_data",   o_imem_data,       32'd0);
        check("rst_waddr",  32'(o_imem_waddr), 32'd0);
        check("rst_wen",    32'(o_imem_wen),   32'd0);
        check("rst_ack",    32'(o_ack),        32'd0);
        i_rst = 1'b0;
        send(8'h4C); send(8'h01); send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        settle();
        check("rst_reload_writes", wr_log.size(), 1);
        if (wr_log.size() == 1) begin
            check("rst_reload_addr", wr_log[0].addr, 0);
            check("rst_reload_data", wr_log[0].data, 32'hDDCCBBAA);
        end

        // Two words, back to back.
        clear_counts();
        for (int i = 0; i < 10; i++) send(two_words[i]);
        settle();
        check("two_writes", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            check("w0_addr",  wr_log[0].addr,      0);
            check("w0_data",  wr_log[0].data,      32'h12345678);
            check("w0_wsize", 32'(wr_log[0].wsize), 32'd2);
            check("w1_addr",  wr_log[1].addr,      1);
            check("w1_data",  wr_log[1].data,      32'hDEADBEEF);
        end
        check("two_ack_count",    ack_count,    1);
        check("two_ack_with_wen", ackwen_count, 1);

        // 33 words: the last wraps onto address 0.
        clear_counts();
        send(8'h4C); send(8'd33);
        for (int w = 0; w < 33; w++) begin
            send(8'(w)); send(8'h00); send(8'h00); send(8'h00);
        end
        settle();
        check("wrap_writes", wr_log.size(), 33);
        if (wr_log.size() == 33) begin
            check("wrap_w31_addr", wr_log[31].addr, 31);
            check("wrap_w31_data", wr_log[31].data, 32'd31);
            check("wrap_w32_addr", wr_log[32].addr, 0);
            check("wrap_w32_data", wr_log[32].data, 32'd32);
        end
        check("wrap_ack_with_wen", ackwen_count, 1);
        check("wrap_ack_count",    ack_count,    1);

        // Empty load.
        clear_counts();
        send(8'h4C); send(8'h00);
        settle();
        check("empty_wen",   wen_count,  0);
        check("empty_ack",   ack_count,  1);
        check("empty_state", 32'(o_state), 32'd0);

        // Run until halt raised ten cycles later.
        clear_counts();
        send(8'h52); idle(9); drive(1'b0, 8'h00, 1'b1);
        settle();
        check("run_halt_en",  en_count,  10);
        check("run_halt_ack", ack_count, 1);

        // 'H' and halt together.
        clear_counts();
        send(8'h52); idle(3); drive(1'b1, 8'h48, 1'b1);
        settle();
        check("run_both_en",  en_count,  4);
        check("run_both_ack", ack_count, 1);

        // 'H' alone.
        clear_counts();
        send(8'h52); idle(2); send(8'h48);
        settle();
        check("run_h_en",  en_count,  3);
        check("run_h_ack", ack_count, 1);

        // Single step; a byte arriving during the step is ignored.
        clear_counts();
        send(8'h53); send(8'h52);
        settle();
        check("step_en",    en_count,  1);
        check("step_ack",   ack_count, 1);
        check("step_state", 32'(o_state), 32'd0);

        // Unknown byte in IDLE.
        clear_counts();
        send(8'h41);
        settle();
        check("unk_en",    en_count,  0);
        check("unk_ack",   ack_count, 0);
        check("unk_wen",   wen_count, 0);
        check("unk_state", 32'(o_state), 32'd0);

        // Load command while running is ignored.
        clear_counts();
        send(8'h52); send(8'h4C); send(8'h01);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'h48);
        settle();
        check("run_l_wen", wen_count, 0);
        check("run_l_en",  en_count,  7);
        check("run_l_ack", ack_count, 1);

        // Reset while running drops the core enable.
        clear_counts();
        send(8'h52); idle(2);
        @(negedge clk); i_rst = 1'b1;
        @(negedge clk); #1;
        check("rst_run_en",    32'(o_cpu_en), 32'd0);
        check("rst_run_state", 32'(o_state),  32'd0);
        i_rst = 1'b0;
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
